// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared widths, FSM states and lane-result bundle
// for the circular cross-correlation peak search.
package xcorr_pkg;

  localparam int LAG_MAX_W = 16;
  localparam int SC_MAX_W  = LAG_MAX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    FLUSH
  } xc_state_e;

  typedef struct packed {
    logic [LAG_MAX_W-1:0] lag;
    logic [SC_MAX_W-1:0]  score;
    logic                 inv;
  } lane_res_t;

  function automatic int lag_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int score_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/xcorr_match_count.sv
// xcorr_match_count: one lane's match popcount with optional
// absolute (anti-correlation) scoring, purely combinational.
module xcorr_match_count
  import xcorr_pkg::*;
#(
  parameter int N = 128
) (
  input  logic [N-1:0]            ref_i,
  input  logic [N-1:0]            sig_i,
  input  logic                    abs_i,
  output logic [score_w(N)-1:0]   score_o,
  output logic                    inv_o
);

  localparam int SW = score_w(N);

  logic [SW-1:0] m;
  logic [SW-1:0] mn;

  always_comb begin
    m = '0;
    for (int i = 0; i < N; i++) begin
      m = m + SW'(ref_i[i] ~^ sig_i[i]);
    end
  end

  assign mn      = SW'(N) - m;
  // a tie at N/2 keeps the direct count
  assign inv_o   = abs_i && (mn > m);
  assign score_o = inv_o ? mn : m;

endmodule

// File: rtl/xcorr_peak_search.sv
// xcorr_peak_search: sweeps all circular lags NLANE per cycle and
// reports the earliest best lag, its score and a threshold detect.
module xcorr_peak_search
  import xcorr_pkg::*;
#(
  parameter int NDATA     = 128,
  parameter int NLANE     = 4,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int NSTEP     = NDATA / NLANE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 absMode,
  input  logic [NDATA_LOG:0]   thr,
  input  logic [NDATA-1:0]     dinRef,
  input  logic [NDATA-1:0]     dinSig,
  output logic                 busy,
  output logic                 done,
  output logic [NDATA_LOG-1:0] peakLag,
  output logic [NDATA_LOG:0]   peakVal,
  output logic                 peakInv,
  output logic                 detect
);

  localparam int LW = NDATA_LOG;
  localparam int SW = score_w(NDATA);
  localparam logic [LW-1:0] LAST = LW'((NSTEP - 1) * NLANE);

  function automatic logic [NDATA-1:0] rotl(
    input logic [NDATA-1:0] x,
    input int               n
  );
    logic [NDATA-1:0] y;
    y = '0;
    for (int i = 0; i < NDATA; i++) begin
      y[(i + n) % NDATA] = x[i];
    end
    return y;
  endfunction

  xc_state_e        state_q, state_d;
  logic [NDATA-1:0] ref_q, ref_d;
  logic [NDATA-1:0] sig_q, sig_d;
  logic             abs_q, abs_d;
  logic [SW-1:0]    thr_q, thr_d;
  logic [LW-1:0]    lag_q, lag_d;
  lane_res_t        st1_q, st1_d;
  lane_res_t        best_q, best_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LW-1:0]    plag_q, plag_d;
  logic [SW-1:0]    pval_q, pval_d;
  logic             pinv_q, pinv_d;
  logic             det_q, det_d;

  logic [NDATA-1:0] lane_sig   [NLANE];
  logic [SW-1:0]    lane_score [NLANE];
  logic             lane_inv   [NLANE];

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign lane_sig[k] = rotl(sig_q, k);
    xcorr_match_count #(.N(NDATA)) u_mc (
      .ref_i   (ref_q),
      .sig_i   (lane_sig[k]),
      .abs_i   (abs_q),
      .score_o (lane_score[k]),
      .inv_o   (lane_inv[k])
    );
  end

  lane_res_t loc;
  lane_res_t merged;

  // strict compare: lower lane keeps ties
  always_comb begin
    loc.lag   = LAG_MAX_W'(lag_q);
    loc.score = SC_MAX_W'(lane_score[0]);
    loc.inv   = lane_inv[0];
    for (int k = 1; k < NLANE; k++) begin
      if (SC_MAX_W'(lane_score[k]) > loc.score) begin
        loc.lag   = LAG_MAX_W'(lag_q + LW'(k));
        loc.score = SC_MAX_W'(lane_score[k]);
        loc.inv   = lane_inv[k];
      end
    end
  end

  assign merged = (st1_q.score > best_q.score) ? st1_q : best_q;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    sig_d   = sig_q;
    abs_d   = abs_q;
    thr_d   = thr_q;
    lag_d   = lag_q;
    st1_d   = st1_q;
    best_d  = best_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    plag_d  = plag_q;
    pval_d  = pval_q;
    pinv_d  = pinv_q;
    det_d   = det_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ref_d   = dinRef;
          sig_d   = dinSig;
          abs_d   = absMode;
          thr_d   = thr;
          lag_d   = '0;
          st1_d   = '0;
          best_d  = '0;
          busy_d  = 1'b1;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        st1_d  = loc;
        best_d = merged;
        sig_d  = rotl(sig_q, NLANE);
        lag_d  = lag_q + LW'(NLANE);
        if (lag_q == LAST) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        best_d  = merged;
        plag_d  = merged.lag[LW-1:0];
        pval_d  = merged.score[SW-1:0];
        pinv_d  = merged.inv;
        det_d   = merged.score >= SC_MAX_W'(thr_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ref_q   <= '0;
      sig_q   <= '0;
      abs_q   <= 1'b0;
      thr_q   <= '0;
      lag_q   <= '0;
      st1_q   <= '0;
      best_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plag_q  <= '0;
      pval_q  <= '0;
      pinv_q  <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      sig_q   <= sig_d;
      abs_q   <= abs_d;
      thr_q   <= thr_d;
      lag_q   <= lag_d;
      st1_q   <= st1_d;
      best_q  <= best_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plag_q  <= plag_d;
      pval_q  <= pval_d;
      pinv_q  <= pinv_d;
      det_q   <= det_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign peakLag = plag_q;
  assign peakVal = pval_q;
  assign peakInv = pinv_q;
  assign detect  = det_q;

endmodule

// File: tb/tb_xcorr_peak_search.sv
// tb_xcorr_peak_search: randomized and directed checks of the peak
// search against a lag-by-lag reference model.
module tb_xcorr_peak_search;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         absMode = 1'b0;
  logic [7:0]   thr = '0;
  logic [127:0] dinRef = '0;
  logic [127:0] dinSig = '0;
  logic         busy, done, peakInv, detect;
  logic [6:0]   peakLag;
  logic [7:0]   peakVal;

  logic [2:0]  s_start = '0;
  logic [15:0] s_ref [3];
  logic [15:0] s_sig [3];
  logic        s_busy [3];
  logic        s_done [3];
  logic [3:0]  s_lag [3];
  logic [4:0]  s_val [3];
  logic        s_inv [3];
  logic        s_det [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xcorr_peak_search #(.NDATA(128), .NLANE(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .absMode(absMode),
    .thr(thr), .dinRef(dinRef), .dinSig(dinSig),
    .busy(busy), .done(done), .peakLag(peakLag),
    .peakVal(peakVal), .peakInv(peakInv), .detect(detect)
  );

  for (genvar g = 0; g < 3; g++) begin : g_small
    localparam int NL = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    xcorr_peak_search #(.NDATA(16), .NLANE(NL)) u_s (
      .clk(clk), .rst(rst), .start(s_start[g]), .absMode(1'b0),
      .thr(5'd16), .dinRef(s_ref[g]), .dinSig(s_sig[g]),
      .busy(s_busy[g]), .done(s_done[g]), .peakLag(s_lag[g]),
      .peakVal(s_val[g]), .peakInv(s_inv[g]), .detect(s_det[g])
    );
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rotr(
    input logic [127:0] x, input int n, input int k
  );
    logic [127:0] y;
    y = '0;
    for (int j = 0; j < n; j++) y[j] = x[(j + k) % n];
    return y;
  endfunction

  function automatic void model(
    input logic [127:0] r, input logic [127:0] s, input int n,
    input bit am, output int blag, output int bval, output bit binv
  );
    int m;
    int sc;
    bit iv;
    blag = 0;
    bval = -1;
    binv = 1'b0;
    for (int l = 0; l < n; l++) begin
      m = 0;
      for (int i = 0; i < n; i++)
        if (r[i] == s[(i - l + n) % n]) m++;
      sc = m;
      iv = 1'b0;
      if (am && (n - m > m)) begin
        sc = n - m;
        iv = 1'b1;
      end
      if (sc > bval) begin
        bval = sc;
        blag = l;
        binv = iv;
      end
    end
  endfunction

  task automatic run_main(
    input logic [127:0] r, input logic [127:0] s, input bit am,
    input logic [7:0] t, input int extra_at, output int lat
  );
    @(negedge clk);
    dinRef = r; dinSig = s; absMode = am; thr = t; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dinRef = ~r; dinSig = rnd128(); absMode = ~am; thr = ~t;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      start = (n == extra_at);
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_sweep edge %0d got %b want 1", n, busy);
      end
    end
    start = 1'b0;
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout got none want done within 60");
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done got %b want 0", busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, peakLag, peakVal, peakInv, detect} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {busy, done, peakLag, peakVal, peakInv, detect});
    end
    rst = 1'b1;
  endtask

  task automatic test_autocorr();
    logic [127:0] r;
    int lat;
    r = rnd128();
    run_main(r, r, 1'b0, 8'd100, 0, lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL auto_latency got %0d want 33", lat);
    end
    checks++;
    if ({peakLag, peakVal, peakInv, detect} !== {7'd0, 8'd128, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL auto_result got lag %0d val %0d inv %b det %b want 0 128 0 1",
               peakLag, peakVal, peakInv, detect);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single got %b want 0", done);
    end
  endtask

  task automatic test_shift();
    logic [127:0] r, s;
    int lat, el, ev;
    bit ei;
    r = rnd128();
    s = rotr(r, 128, 37);
    model(r, s, 128, 1'b0, el, ev, ei);
    run_main(r, s, 1'b0, 8'd129, 0, lat);
    checks++;
    if ({peakLag, peakVal, peakInv, detect} !== {7'(el), 8'd128, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL shift37 got lag %0d val %0d inv %b det %b want %0d 128 0 0",
               peakLag, peakVal, peakInv, detect, el);
    end
  endtask

  task automatic test_inverted();
    logic [127:0] r, s;
    int lat, el, ev;
    bit ei;
    r = rnd128();
    s = ~rotr(r, 128, 5);
    model(r, s, 128, 1'b1, el, ev, ei);
    run_main(r, s, 1'b1, 8'd128, 0, lat);
    checks++;
    if ({peakLag, peakVal, peakInv, detect} !== {7'(el), 8'd128, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL inv_abs got lag %0d val %0d inv %b det %b want %0d 128 1 1",
               peakLag, peakVal, peakInv, detect, el);
    end
    model(r, s, 128, 1'b0, el, ev, ei);
    run_main(r, s, 1'b0, 8'd0, 0, lat);
    checks++;
    if ({peakLag, peakVal, peakInv, detect} !== {7'(el), 8'(ev), 1'b0, 1'b1}
        || peakVal >= 8'd128) begin
      errors++;
      $display("FAIL inv_match got lag %0d val %0d inv %b want %0d %0d 0",
               peakLag, peakVal, peakInv, el, ev);
    end
  endtask

  task automatic test_all_tie();
    int lat;
    run_main('0, '0, 1'b0, 8'd128, 0, lat);
    checks++;
    if ({peakLag, peakVal, peakInv, detect} !== {7'd0, 8'd128, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL all_tie got lag %0d val %0d want 0 128", peakLag, peakVal);
    end
  endtask

  task automatic test_random();
    logic [127:0] r, s;
    logic [7:0] t;
    bit am;
    int lat, el, ev;
    bit ei;
    for (int i = 0; i < 6; i++) begin
      r = rnd128();
      s = (i % 2 == 0) ? rnd128() : rotr(r ^ 128'(1 << i), 128, $urandom_range(127));
      am = $urandom_range(1);
      t = 8'($urandom_range(129));
      model(r, s, 128, am, el, ev, ei);
      run_main(r, s, am, t, 0, lat);
      checks++;
      if ({peakLag, peakVal, peakInv, detect} !==
          {7'(el), 8'(ev), ei, (ev >= int'(t))}) begin
        errors++;
        $display("FAIL random_%0d got lag %0d val %0d inv %b det %b want %0d %0d %b %b",
                 i, peakLag, peakVal, peakInv, detect, el, ev, ei, ev >= int'(t));
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [127:0] r, s;
    int lat, el, ev, extra;
    bit ei;
    r = rnd128();
    s = rotr(r, 128, 77);
    model(r, s, 128, 1'b0, el, ev, ei);
    run_main(r, s, 1'b0, 8'd50, 10, lat);
    checks++;
    if (lat !== 33 || {peakLag, peakVal} !== {7'(el), 8'(ev)}) begin
      errors++;
      $display("FAIL restart_ignored got lat %0d lag %0d val %0d want 33 %0d %0d",
               lat, peakLag, peakVal, el, ev);
    end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL restart_queued got %0d extra done want 0", extra);
    end
  endtask

  task automatic test_abort();
    logic [127:0] r, s;
    int lat, seen, el, ev;
    bit ei;
    @(negedge clk);
    dinRef = rnd128(); dinSig = rnd128(); absMode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, peakLag, peakVal, peakInv, detect} !== '0) begin
      errors++;
      $display("FAIL abort_clear got %h want 0",
               {busy, done, peakLag, peakVal, peakInv, detect});
    end
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_resume got %0d busy/done cycles want 0", seen);
    end
    r = rnd128();
    s = rotr(r, 128, 100);
    model(r, s, 128, 1'b0, el, ev, ei);
    run_main(r, s, 1'b0, 8'd128, 0, lat);
    checks++;
    if (lat !== 33 || {peakLag, peakVal, detect} !== {7'(el), 8'(ev), 1'b1}) begin
      errors++;
      $display("FAIL abort_rerun got lat %0d lag %0d val %0d want 33 %0d %0d",
               lat, peakLag, peakVal, el, ev);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    dinRef = rnd128(); dinSig = dinRef; absMode = 1'b0; start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 !== 33 || d2 !== 67) begin
      errors++;
      $display("FAIL back_to_back got done edges %0d %0d want 33 67", d1, d2);
    end
  endtask

  task automatic test_small();
    logic [127:0] r, s;
    int lat [3];
    int el, ev;
    bit ei;
    int want [3];
    want = '{17, 5, 2};
    r = 128'($urandom_range(16'hffff));
    s = rotr(r, 16, 9);
    model(r, s, 16, 1'b0, el, ev, ei);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      s_ref[g] = r[15:0];
      s_sig[g] = s[15:0];
      lat[g] = -1;
    end
    s_start = 3'b111;
    @(posedge clk);
    @(negedge clk);
    s_start = 3'b000;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (s_done[g] === 1'b1 && lat[g] < 0) lat[g] = n;
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (lat[g] !== want[g] || {s_lag[g], s_val[g]} !== {4'(el), 5'd16}) begin
        errors++;
        $display("FAIL small_%0d got lat %0d lag %0d val %0d want %0d %0d 16",
                 g, lat[g], s_lag[g], s_val[g], want[g], el);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      s_ref[g] = '0;
      s_sig[g] = '0;
    end
    test_reset();
    test_autocorr();
    test_shift();
    test_inverted();
    test_all_tie();
    test_random();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcorr_peak_search.md
Name: xcorr_peak_search

Overview:
Next-generation correlation peak finder. A start pulse captures a reference vector and a signal vector. The block then sweeps all NDATA circular lags, NLANE lags per cycle, and reports the best lag, its score, an inversion flag and a threshold detect flag. Compared with the fixed 4-lane, externally-counted array it adds:
- parametrised lane count
- an internal sweep sequencer with a start/busy/done handshake
- an optional absolute (anti-correlation) scoring mode
- a programmable detection threshold

Parameters:
NDATA, 128, vector width in bits; power of 2, at least 4.
NLANE, 4, lags scored per cycle; power of 2, 1 to NDATA.
NDATA_LOG, $clog2(NDATA), derived; do not override.
NSTEP, NDATA/NLANE, derived sweep length in cycles.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset; synchronous, active-low.
start  in  1  one-cycle request; honoured only when busy=0.
absMode  in  1  0 = match scoring; 1 = absolute scoring. Sampled with start.
thr  in  NDATA_LOG+1  detection threshold. Sampled with start.
dinRef  in  NDATA  reference vector. Sampled with start.
dinSig  in  NDATA  signal vector. Sampled with start.
busy  out  1  high from the start-accept edge until the edge that asserts done.
done  out  1  one-cycle pulse when results update.
peakLag  out  NDATA_LOG  best lag.
peakVal  out  NDATA_LOG+1  best score, 0 to NDATA.
peakInv  out  1  best score came from the inverted match count.
detect  out  1  peakVal >= latched thr.

Behaviour:
- Reset: one clock, synchronous, active-low; the reset is already decided. When rst=0 at an edge, all outputs, the FSM state, the step counter and the running best clear to 0. Reset mid-sweep aborts the sweep with no done pulse.
- Score definition: for lag L, m(L) = popcount(~(dinRef ^ rotl(dinSig, L))), where rotl(x,1) = {x[NDATA-2:0], x[NDATA-1]}.
  - absMode=0: score = m, inv = 0.
  - absMode=1: score = max(m, NDATA-m), inv = (NDATA-m > m). A tie at NDATA/2 gives inv = 0.
- FSM states: IDLE, SWEEP, FLUSH.
  - IDLE: start=1 at an edge (E0) latches dinRef, dinSig, absMode and thr; sets busy=1; clears step and the running best; enters SWEEP.
  - SWEEP at step s (0..NSTEP-1): lane k scores lag s*NLANE+k.
  - Signal rotation: the working signal register rotates left by NLANE each cycle, so there is no variable barrel shifter. Lane k applies a fixed rotation of k.
  - Stage 1: an in-lane compare tree picks the local best; on ties the lower k wins. Lag, score and inv are registered.
  - Stage 2: the running best is replaced only when the stage-1 score is strictly greater, so the earliest (lowest) lag wins ties across steps.
  - After step NSTEP-1, go to FLUSH.
  - FLUSH: merge the last stage-1 entry. Load peakLag, peakVal, peakInv and detect from the final best. Assert done=1 and busy=0. Return to IDLE.
- Latency: done is asserted by edge E(NSTEP+1), i.e. 33 edges after E0 at the default parameters.
- start while busy=1 is ignored, with no queueing. start coincident with the done edge is also ignored; it is accepted from the next cycle onward.
- Outputs hold their values until the next done. done is never high for two consecutive cycles.
- Width rules:
  - Scores use NDATA_LOG+1 bits, since an all-match score equals NDATA.
  - Lags use NDATA_LOG bits.
  - The lag counter wraps naturally after the final step and is never observed beyond NDATA-1.

Decomposition:
- Shared package xcorr_pkg holds:
  - score/lag width helper functions (score width = $clog2(N)+1)
  - the FSM state enum (IDLE, SWEEP, FLUSH)
  - a lane-result struct {lag, score, inv}
- One sub-module: xcorr_match_count. It takes ref, rotated signal and absMode, and outputs score and inv combinationally. It is instantiated NLANE times with generate.
- The compare tree and the FSM stay in the top module.

Test Plan:
- NDATA=128, NLANE=4, dinRef=dinSig=pseudo-random pattern with a unique autocorrelation peak, absMode=0, thr=100 -> after 33 cycles: peakLag=0, peakVal=128, peakInv=0, detect=1, single done pulse, busy high for cycles 1-32.
- dinSig = rotr(dinRef,37) -> peakLag=37, peakVal=128; with thr=129, detect=0.
- dinSig = ~rotr(dinRef,5), absMode=1 -> peakLag=5, peakVal=128, peakInv=1. Same vectors with absMode=0 -> peakInv=0 and peakVal<128.
- dinRef=dinSig=all zeros -> every lag scores 128 (tie) -> peakLag=0, peakVal=128.
- Pulse start again at cycle 10 of a sweep -> ignored: exactly one done, results match the first request. Assert rst=0 at cycle 15 of a second sweep -> all outputs 0, no done, busy=0 next cycle; a new start then completes normally.
- Parameter sweep NDATA=16 with NLANE in {1, 4, 16} and dinSig=rotr(dinRef,9) -> peakLag=9, peakVal=16, done after 17/5/2 edges respectively.
